// File: rtl/arm_boot_loader.sv
// arm_boot_loader: boot-time image loader and memory-port multiplexer.
// After reset the loader owns the memory port and holds the CPU in reset.
// It receives a byte stream: a 4-byte little-endian word count N, then N
// little-endian words, then one XOR checksum byte. The loader writes each
// word from BaseAddress upward. When the checksum matches, it hands the
// memory port to the CPU and releases the CPU reset.
module arm_boot_loader #(
  parameter int                   BusWidth    = 32,
  parameter logic [BusWidth-1:0]  BaseAddress = '0,
  parameter int                   MaxWords    = 1024
) (
  input  logic                i_CLK,
  input  logic                i_NRESET,
  input  logic [7:0]          i_RxData,
  input  logic                i_RxValid,
  output logic                o_RxReady,
  input  logic                i_Reload,
  input  logic                i_CPU_MemWrite,
  input  logic [BusWidth-1:0] i_CPU_Address,
  input  logic [BusWidth-1:0] i_CPU_WriteData,
  output logic [BusWidth-1:0] o_CPU_ReadData,
  output logic                o_CPU_NRESET,
  output logic                o_MemWrite,
  output logic [BusWidth-1:0] o_Address,
  output logic [BusWidth-1:0] o_WriteData,
  input  logic [BusWidth-1:0] i_ReadData,
  output logic                o_Busy,
  output logic                o_Done,
  output logic                o_Error
);

  localparam int          W         = BusWidth / 8;
  localparam int          IDX_W     = $clog2(MaxWords + 1);
  localparam int          MAXB      = (W > 4) ? W : 4;
  localparam int          BCNT_W    = (MAXB > 1) ? $clog2(MAXB) : 1;
  localparam logic [31:0] MAX_WORDS = 32'(MaxWords);

  typedef enum logic [2:0] {
    S_COUNT,
    S_DATA,
    S_WRITE,
    S_CHECK,
    S_RUN,
    S_ERROR
  } state_t;

  state_t              state_q, state_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [BusWidth-1:0] word_q, word_d;
  logic [7:0]          xsum_q, xsum_d;
  logic [31:0]         count_q, count_d;
  logic                cpu_nrst_q, cpu_nrst_d;

  logic                  rx_ready;
  logic                  rx_fire;
  logic [BusWidth+7:0]   word_cat;
  logic [BusWidth-1:0]   loader_addr;

  // Accepting a byte only in the states that consume stream data.
  assign rx_ready = (state_q == S_COUNT) || (state_q == S_DATA) || (state_q == S_CHECK);
  assign rx_fire  = i_RxValid & rx_ready;

  // Each new byte enters at the top of the word. After W bytes, the first byte is the LSB.
  assign word_cat = {i_RxData, word_q};

  // The loader's write address follows the current word index.
  assign loader_addr = BaseAddress + (BusWidth'(index_q) * BusWidth'(W));

  // Next-state logic: stream parsing, word assembly, checksum and reload.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    index_d = index_q;
    word_d  = word_q;
    xsum_d  = xsum_q;
    count_d = count_q;

    case (state_q)
      S_COUNT: begin
        if (rx_fire) begin
          xsum_d  = xsum_q ^ i_RxData;
          count_d = {i_RxData, count_q[31:8]};
          if (bcnt_q == BCNT_W'(3)) begin
            bcnt_d = '0;
            if (count_d > MAX_WORDS) begin
              state_d = S_ERROR;
            end else if (count_d == 32'd0) begin
              state_d = S_CHECK;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (rx_fire) begin
          xsum_d = xsum_q ^ i_RxData;
          word_d = word_cat[BusWidth+7:8];
          if (bcnt_q == BCNT_W'(W - 1)) begin
            bcnt_d  = '0;
            state_d = S_WRITE;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end

      S_WRITE: begin
        index_d = index_q + 1'b1;
        if (32'(index_d) < count_q) begin
          state_d = S_DATA;
        end else begin
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (rx_fire) begin
          state_d = (i_RxData == xsum_q) ? S_RUN : S_ERROR;
        end
      end

      S_RUN, S_ERROR: begin
        if (i_Reload) begin
          state_d = S_COUNT;
          bcnt_d  = '0;
          index_d = '0;
          word_d  = '0;
          xsum_d  = '0;
          count_d = '0;
        end
      end

      default: begin
        state_d = S_COUNT;
      end
    endcase

    // The CPU reset is registered so that it changes on the same edge as the memory mux.
    cpu_nrst_d = (state_d == S_RUN);
  end

  // State register and loader datapath registers.
  always_ff @(posedge i_CLK or negedge i_NRESET) begin
    if (!i_NRESET) begin
      state_q    <= S_COUNT;
      bcnt_q     <= '0;
      index_q    <= '0;
      word_q     <= '0;
      xsum_q     <= '0;
      count_q    <= '0;
      cpu_nrst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      index_q    <= index_d;
      word_q     <= word_d;
      xsum_q     <= xsum_d;
      count_q    <= count_d;
      cpu_nrst_q <= cpu_nrst_d;
    end
  end

  // Memory port mux: the CPU passes straight through in RUN; otherwise the loader drives the port.
  always_comb begin
    o_MemWrite  = 1'b0;
    o_Address   = loader_addr;
    o_WriteData = word_q;
    if (state_q == S_RUN) begin
      o_MemWrite  = i_CPU_MemWrite;
      o_Address   = i_CPU_Address;
      o_WriteData = i_CPU_WriteData;
    end else if (state_q == S_WRITE) begin
      o_MemWrite = 1'b1;
    end
  end

  assign o_RxReady      = rx_ready;
  assign o_CPU_ReadData = i_ReadData;
  assign o_CPU_NRESET   = cpu_nrst_q;
  assign o_Busy         = (state_q == S_COUNT) || (state_q == S_DATA) ||
                          (state_q == S_WRITE) || (state_q == S_CHECK);
  assign o_Done         = (state_q == S_RUN);
  assign o_Error        = (state_q == S_ERROR);

endmodule

// File: tb/tb_arm_boot_loader.sv
// Directed bench for arm_boot_loader (32-bit bus, base 0x100, MaxWords 4).
module tb_arm_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        reload;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_nrst;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [7:0]  stim[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          reload_at = -1;

  always #5 clk = ~clk;

  arm_boot_loader #(
    .BusWidth   (32),
    .BaseAddress(32'h0000_0100),
    .MaxWords   (4)
  ) dut (
    .i_CLK          (clk),
    .i_NRESET       (rst_n),
    .i_RxData       (rx_data),
    .i_RxValid      (rx_valid),
    .o_RxReady      (rx_ready),
    .i_Reload       (reload),
    .i_CPU_MemWrite (cpu_we),
    .i_CPU_Address  (cpu_addr),
    .i_CPU_WriteData(cpu_wdata),
    .o_CPU_ReadData (cpu_rdata),
    .o_CPU_NRESET   (cpu_nrst),
    .o_MemWrite     (mem_we),
    .o_Address      (mem_addr),
    .o_WriteData    (mem_wdata),
    .i_ReadData     (mem_rdata),
    .o_Busy         (busy),
    .o_Done         (done),
    .o_Error        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Record loader writes while the CPU is held in reset.
  always @(negedge clk) begin
    if (rst_n && mem_we && !cpu_nrst) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
      chk("rdy_in_write", {31'd0, rx_ready}, 32'd0);
    end
  end

  // Offer one byte, starting and ending at a falling edge, with optional random idle gaps.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        @(negedge clk);
      end
    end
    rx_valid = 1'b1;
    rx_data  = b;
    n = 0;
    while (!rx_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("rx_timeout", {31'd0, rx_ready}, 32'd1);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_stim(input bit gaps);
    for (int i = 0; i < stim.size(); i++) begin
      if (i == reload_at) begin
        rx_valid = 1'b0;
        reload   = 1'b1;
        @(negedge clk);
        reload   = 1'b0;
      end
      send_byte(stim[i], gaps);
    end
  endtask

  task automatic reload_pulse();
    reload = 1'b1;
    @(posedge clk);
    #1;
    chk("reload_nrst", {31'd0, cpu_nrst}, 32'd0);
    chk("reload_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    reload = 1'b0;
    chk("reload_rdy", {31'd0, rx_ready}, 32'd1);
  endtask

  task automatic set_good2();
    stim = {8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h64};
  endtask

  task automatic check_two_writes(input string tag);
    chk({tag, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      chk({tag, "_a0"}, wr_addr[0], 32'h0000_0100);
      chk({tag, "_d0"}, wr_data[0], 32'h1122_3344);
      chk({tag, "_a1"}, wr_addr[1], 32'h0000_0104);
      chk({tag, "_d1"}, wr_data[1], 32'hDEAD_BEEF);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    reload    = 1'b0;
    cpu_we    = 1'b1;
    cpu_addr  = 32'h0000_ABC0;
    cpu_wdata = 32'h5555_AAAA;
    mem_rdata = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_rdy",   {31'd0, rx_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy},     32'd1);
    chk("rst_done",  {31'd0, done},     32'd0);
    chk("rst_err",   {31'd0, err},      32'd0);
    chk("rst_nrst",  {31'd0, cpu_nrst}, 32'd0);
    chk("rst_we",    {31'd0, mem_we},   32'd0);
    chk("rst_addr",  mem_addr,          32'h0000_0100);
    chk("rst_wdata", mem_wdata,         32'd0);
    chk("rst_rdata", cpu_rdata,         32'hCAFE_F00D);
    rst_n = 1'b1;
    @(negedge clk);

    // N=2 load at full rate
    wr_addr.delete(); wr_data.delete();
    set_good2();
    send_stim(1'b0);
    check_two_writes("load2");
    chk("load2_done", {31'd0, done},     32'd1);
    chk("load2_nrst", {31'd0, cpu_nrst}, 32'd1);
    chk("load2_busy", {31'd0, busy},     32'd0);
    chk("pass_we",    {31'd0, mem_we},   32'd1);
    chk("pass_addr",  mem_addr,          32'h0000_ABC0);
    chk("pass_wdata", mem_wdata,         32'h5555_AAAA);
    mem_rdata = 32'h1357_9BDF;
    #1;
    chk("pass_rdata", cpu_rdata,         32'h1357_9BDF);

    // Empty image
    reload_pulse();
    wr_addr.delete(); wr_data.delete();
    stim = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_stim(1'b0);
    chk("empty_nwr",  32'(wr_addr.size()), 32'd0);
    chk("empty_done", {31'd0, done},       32'd1);

    // Bad checksum, then recover
    reload_pulse();
    wr_addr.delete(); wr_data.delete();
    set_good2();
    stim[12] = 8'h65;
    send_stim(1'b0);
    check_two_writes("badck");
    chk("badck_err",  {31'd0, err},      32'd1);
    chk("badck_nrst", {31'd0, cpu_nrst}, 32'd0);
    chk("badck_rdy",  {31'd0, rx_ready}, 32'd0);
    chk("badck_we",   {31'd0, mem_we},   32'd0);
    reload_pulse();
    set_good2();
    send_stim(1'b0);
    chk("recover_done", {31'd0, done}, 32'd1);

    // Oversize count
    reload_pulse();
    stim = {8'h05, 8'h00, 8'h00, 8'h00};
    send_stim(1'b0);
    chk("over_err",  {31'd0, err},      32'd1);
    chk("over_rdy",  {31'd0, rx_ready}, 32'd0);
    chk("over_busy", {31'd0, busy},     32'd0);

    // Handshake gaps with an ignored reload pulse mid-load
    reload_pulse();
    wr_addr.delete(); wr_data.delete();
    set_good2();
    reload_at = 6;
    send_stim(1'b1);
    reload_at = -1;
    check_two_writes("gaps");
    chk("gaps_done", {31'd0, done}, 32'd1);

    // Asynchronous reset in the middle of word 0
    reload_pulse();
    stim = {8'h02, 8'h00, 8'h00, 8'h00, 8'h44, 8'h33};
    send_stim(1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we",    {31'd0, mem_we},   32'd0);
    chk("arst_nrst",  {31'd0, cpu_nrst}, 32'd0);
    chk("arst_busy",  {31'd0, busy},     32'd1);
    chk("arst_addr",  mem_addr,          32'h0000_0100);
    chk("arst_wdata", mem_wdata,         32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wr_addr.delete(); wr_data.delete();
    stim = {8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    send_stim(1'b0);
    chk("n1_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      chk("n1_a0", wr_addr[0], 32'h0000_0100);
      chk("n1_d0", wr_data[0], 32'h1234_5678);
    end
    chk("n1_done", {31'd0, done},     32'd1);
    chk("n1_nrst", {31'd0, cpu_nrst}, 32'd1);

    // Reload from RUN: CPU reset falls on the next edge and loader state is cleared
    reload_pulse();
    chk("rl_addr",  mem_addr,      32'h0000_0100);
    chk("rl_wdata", mem_wdata,     32'd0);
    chk("rl_done",  {31'd0, done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
